// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state, owner and access-size encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch and load/store;
// data wins every arbitration and at most one transaction is outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e state_q;
  arb_owner_e owner_q;
  logic       owner_req;
  logic       in_req;
  logic       in_wait;

  assign owner_req = (owner_q == OwnerData) ? data_req : inst_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnerInst;
    end else begin
      case (state_q)
        StIdle: begin
          if (data_req) begin
            owner_q <= OwnerData;
            state_q <= StReq;
          end else if (inst_req) begin
            owner_q <= OwnerInst;
            state_q <= StReq;
          end
        end
        StReq: begin
          // A withdrawn request abandons the grant without touching memory.
          if (owner_req && mem_addr_ok) begin
            state_q <= StWait;
          end else if (!owner_req) begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (mem_data_ok) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshakes are gated by reset so nothing leaks out while it is asserted.
  assign in_req  = (state_q == StReq) && !reset;
  assign in_wait = (state_q == StWait) && !reset;

  always_comb begin
    mem_req      = in_req && owner_req;
    mem_wr       = inst_wr;
    mem_size     = inst_size;
    mem_addr     = inst_addr;
    mem_wdata    = inst_wdata;
    if (owner_q == OwnerData) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
    inst_addr_ok = in_req && (owner_q == OwnerInst) && mem_addr_ok;
    data_addr_ok = in_req && (owner_q == OwnerData) && mem_addr_ok;
    inst_data_ok = in_wait && (owner_q == OwnerInst) && mem_data_ok;
    data_data_ok = in_wait && (owner_q == OwnerData) && mem_data_ok;
    inst_rdata   = in_wait ? mem_rdata : 32'h0;
    data_rdata   = in_wait ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven just after posedge; outputs are checked at negedge.
  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        maok;
    logic        mdok;
    logic [31:0] rdata;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_wr;
    logic        e_iaok;
    logic        e_daok;
    logic        e_idok;
    logic        e_ddok;
  } vec_t;

  localparam logic [31:0] IAddr = 32'hbfc00000;
  localparam logic [31:0] DAddr = 32'h80001000;

  vec_t tbl[20];

  function automatic vec_t mk(input logic rst, input logic ireq, input logic dreq,
                              input logic maok, input logic mdok, input logic [31:0] rdata,
                              input logic e_mreq, input logic [31:0] e_addr, input logic e_wr,
                              input logic e_iaok, input logic e_daok,
                              input logic e_idok, input logic e_ddok);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.maok = maok; v.mdok = mdok;
    v.rdata = rdata; v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_wr = e_wr;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    return v;
  endfunction

  // Reference model state: a granted-but-unaccepted request, or an accepted
  // transaction awaiting its data, each belonging to one requester.
  bit m_granted, m_issued, m_to_data;

  initial begin
    int dok_cycles[$];
    logic [31:0] held_addr;
    bit r_req, e_mreq, e_iaok, e_daok, e_idok, e_ddok;

    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IAddr; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b1; data_size = 2'd2; data_addr = DAddr;
    data_wdata = 32'hdeadbeef;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // rst ireq dreq maok mdok rdata | mreq addr wr iaok daok idok ddok
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 1, 32'h11111111, 0, 0,     0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 0, 32'h0,        1, IAddr, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 32'h24080001, 0, 0,     0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 32'h0,        1, DAddr, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 1, 0, 32'h0,        1, DAddr, 1, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 1, 32'h5a5a0001, 0, 0,     0, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 32'h0,        1, IAddr, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 0, 32'h0,        1, DAddr, 1, 0, 1, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 1, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 1, 1, 1, 32'h0,        0, 0,     0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 1, 32'h0,        1, DAddr, 1, 0, 0, 0, 0);

    to_next();
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
      mem_addr_ok = tbl[i].maok; mem_data_ok = tbl[i].mdok; mem_rdata = tbl[i].rdata;
      to_negedge();
      chk($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_mreq));
      chk($sformatf("vec%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(tbl[i].e_iaok));
      chk($sformatf("vec%0d data_addr_ok", i), 32'(data_addr_ok), 32'(tbl[i].e_daok));
      chk($sformatf("vec%0d inst_data_ok", i), 32'(inst_data_ok), 32'(tbl[i].e_idok));
      chk($sformatf("vec%0d data_data_ok", i), 32'(data_data_ok), 32'(tbl[i].e_ddok));
      if (tbl[i].e_mreq) begin
        chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d mem_wr", i), 32'(mem_wr), 32'(tbl[i].e_wr));
      end
      if (tbl[i].e_idok) chk($sformatf("vec%0d inst_rdata", i), inst_rdata, tbl[i].rdata);
      if (tbl[i].e_ddok) chk($sformatf("vec%0d data_rdata", i), data_rdata, tbl[i].rdata);
      to_next();
    end

    // Stalled accept: request must hold steady while memory refuses it.
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    to_next();
    reset = 1'b0; data_req = 1'b1; data_addr = 32'h80002040;
    to_next();
    for (int c = 0; c < 5; c++) begin
      to_negedge();
      chk($sformatf("stall%0d mem_req", c), 32'(mem_req), 32'd1);
      chk($sformatf("stall%0d mem_addr", c), mem_addr, 32'h80002040);
      chk($sformatf("stall%0d data_addr_ok", c), 32'(data_addr_ok), 32'd0);
      to_next();
    end
    mem_addr_ok = 1'b1;
    to_negedge();
    chk("stall accept data_addr_ok", 32'(data_addr_ok), 32'd1);
    to_next();

    // Back-to-back with zero-wait memory: data always wins, 3-cycle spacing.
    reset = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; data_addr = DAddr;
    to_next();
    reset = 1'b0; data_req = 1'b1; inst_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      to_negedge();
      if (data_data_ok) dok_cycles.push_back(c);
      chk($sformatf("b2b%0d inst_addr_ok", c), 32'(inst_addr_ok), 32'd0);
      to_next();
    end
    chk("b2b pulse count", 32'(dok_cycles.size()), 32'd4);
    for (int k = 0; k < dok_cycles.size(); k++)
      chk($sformatf("b2b pulse%0d cycle", k), 32'(dok_cycles[k]), 32'(2 + 3 * k));

    // Randomized run against the reference model.
    m_granted = 1'b0; m_issued = 1'b0; m_to_data = 1'b0;
    held_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      reset       = (c == 0) || ($urandom_range(0, 49) == 0);
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 4);
      inst_wr     = 1'b0;
      inst_size   = 2'($urandom_range(0, 2));
      inst_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wr     = 1'($urandom);
      data_size   = 2'($urandom_range(0, 2));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = 1'($urandom);
      mem_data_ok = 1'($urandom);
      mem_rdata   = $urandom;
      to_negedge();
      r_req  = m_to_data ? data_req : inst_req;
      e_mreq = !reset && m_granted && r_req;
      e_iaok = !reset && m_granted && !m_to_data && mem_addr_ok;
      e_daok = !reset && m_granted && m_to_data && mem_addr_ok;
      e_idok = !reset && m_issued && !m_to_data && mem_data_ok;
      e_ddok = !reset && m_issued && m_to_data && mem_data_ok;
      chk("rnd mem_req", 32'(mem_req), 32'(e_mreq));
      chk("rnd inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      chk("rnd data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      chk("rnd inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
      chk("rnd data_data_ok", 32'(data_data_ok), 32'(e_ddok));
      if (e_mreq) begin
        held_addr = m_to_data ? data_addr : inst_addr;
        chk("rnd mem_addr", mem_addr, held_addr);
        chk("rnd mem_wr", 32'(mem_wr), 32'(m_to_data ? data_wr : inst_wr));
        chk("rnd mem_size", 32'(mem_size), 32'(m_to_data ? data_size : inst_size));
        chk("rnd mem_wdata", mem_wdata, m_to_data ? data_wdata : inst_wdata);
      end
      if (e_idok) chk("rnd inst_rdata", inst_rdata, mem_rdata);
      if (e_ddok) chk("rnd data_rdata", data_rdata, mem_rdata);
      if (reset) begin
        m_granted = 1'b0; m_issued = 1'b0; m_to_data = 1'b0;
      end else if (m_granted) begin
        m_granted = 1'b0;
        if (r_req && mem_addr_ok) m_issued = 1'b1;
        else if (r_req) m_granted = 1'b1;
      end else if (m_issued) begin
        if (mem_data_ok) m_issued = 1'b0;
      end else if (data_req || inst_req) begin
        m_granted = 1'b1;
        m_to_data = data_req;
      end
      to_next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
